qformat_mac: RTL and testbench

Pipelined signed fixed-point multiply-accumulate unit for Q(INT_BITS).(FRAC_BITS) operands, with valid/ready handshakes on input and output. It generalises the team's signed Q-format arithmetic to configurable integer and fraction widths, guard bits, rounding mode and saturation. It is the arithmetic core for dot-product and filter datapaths in the inference blocks. Each beat multiplies two operands into a wide accumulator. A `last`-tagged beat emits one rounded, saturated Q-format result.

---
 rtl/qformat_mac.sv | 98 +++++++++
 tb/tb_qformat_mac.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qformat_mac.sv
// Pipelined signed Q(INT_BITS).(FRAC_BITS) multiply-accumulate with valid/ready handshakes.
// Stage 1 registers the product; stage 2 accumulates and loads the rounded, saturated result.
module qformat_mac #(
  parameter int INT_BITS   = 7,
  parameter int FRAC_BITS  = 8,
  parameter int GUARD_BITS = 4,
  parameter int ROUND_MODE = 1,
  parameter int SAT_EN     = 1,
  localparam int W         = 1 + INT_BITS + FRAC_BITS,
  localparam int ACC_W     = 2 * W + GUARD_BITS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_first,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_ovf
);

  localparam logic [ACC_W:0] HALF = (ACC_W + 1)'(1) << (FRAC_BITS - 1);

  logic                      en;
  logic                      s1_valid;
  logic                      s1_first;
  logic                      s1_last;
  logic signed [2*W-1:0]     s1_prod;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_next;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W:0]     r_sum;
  logic signed [ACC_W:0]     r;
  logic [ACC_W-W+1:0]        r_top;
  logic                      res_ovf;
  logic [W-1:0]              res_data;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_comb begin
    prod_ext = ACC_W'(s1_prod);
    acc_next = s1_first ? prod_ext : acc + prod_ext;
  end

  // One extra bit above the accumulator keeps the rounding add from wrapping.
  always_comb begin
    r_sum = {acc_next[ACC_W-1], acc_next};
    if (ROUND_MODE != 0) begin
      r_sum = r_sum + HALF;
    end
    r = r_sum >>> FRAC_BITS;
  end

  // Result fits in W bits only when every bit from the W-1 position upward matches the sign.
  always_comb begin
    r_top   = r[ACC_W:W-1];
    res_ovf = !((&r_top) || !(|r_top));
    if (res_ovf && (SAT_EN != 0)) begin
      res_data = r[ACC_W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      res_data = r[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_prod   <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_prod  <= $signed(in_a) * $signed(in_b);
        s1_first <= in_first;
        s1_last  <= in_last;
      end
      if (s1_valid) begin
        acc <= acc_next;
      end
      out_valid <= s1_valid && s1_last;
      if (s1_valid && s1_last) begin
        out_data <= res_data;
        out_ovf  <= res_ovf;
      end
    end
  end

endmodule

// File: tb/tb_qformat_mac.sv
// Directed bench for qformat_mac: a default instance (round, saturate) and a
// truncating/wrapping instance share all inputs so both modes are checked per beat.
module tb_qformat_mac;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;

  logic        in_ready, out_valid, out_ovf;
  logic [15:0] out_data;
  logic        t_in_ready, t_out_valid, t_out_ovf;
  logic [15:0] t_out_data;

  int n_pass = 0;
  int n_total = 0;

  logic [16:0] q_r[$];
  logic [16:0] q_t[$];

  always #5 clk = ~clk;

  qformat_mac dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
  );

  qformat_mac #(.ROUND_MODE(0), .SAT_EN(0)) dut_t (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(t_in_ready),
    .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
    .out_valid(t_out_valid), .out_ready(out_ready), .out_data(t_out_data), .out_ovf(t_out_ovf)
  );

  // Results are logged on the negedge before the consuming rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) q_r.push_back({out_ovf, out_data});
      if (t_out_valid && out_ready) q_t.push_back({t_out_ovf, t_out_data});
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  // Called #1 after a rising edge; returns #1 after the edge that accepted the beat.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic f, input logic l);
    bit done;
    done = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_first = f; in_last = l;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    n_total++;
    if (done !== 1'b1) $display("FAIL send_accept a=%h b=%h got=%0b want=1", a, b, done);
    else n_pass++;
  endtask

  task automatic drain();
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b want=0", out_valid); else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b want=1", in_ready); else n_pass++;
    n_total++;
    if (out_data !== 16'h0000) $display("FAIL rst_out_data got=%h want=0000", out_data); else n_pass++;
    n_total++;
    if (out_ovf !== 1'b0) $display("FAIL rst_out_ovf got=%b want=0", out_ovf); else n_pass++;
    n_total++;
    if (t_out_valid !== 1'b0) $display("FAIL rst_t_out_valid got=%b want=0", t_out_valid); else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    q_r.delete(); q_t.delete();
    send(16'h0180, 16'h0200, 1'b1, 1'b1);
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL single_early got=%b want=0", out_valid); else n_pass++;
    for (int i = 0; i < 5 && !out_valid; i++) @(negedge clk);
    n_total++;
    if (out_valid !== 1'b1) $display("FAIL single_valid got=%b want=1", out_valid); else n_pass++;
    n_total++;
    if (out_data !== 16'h0300) $display("FAIL single_data got=%h want=0300", out_data); else n_pass++;
    n_total++;
    if (out_ovf !== 1'b0) $display("FAIL single_ovf got=%b want=0", out_ovf); else n_pass++;
    n_total++;
    if (t_out_data !== 16'h0300) $display("FAIL single_t_data got=%h want=0300", t_out_data); else n_pass++;
    drain();
    n_total++;
    if (q_r.size() !== 1) $display("FAIL single_count got=%0d want=1", q_r.size()); else n_pass++;
  endtask

  task automatic test_accumulate();
    q_r.delete(); q_t.delete();
    send(16'h0100, 16'h0040, 1'b1, 1'b0);
    send(16'h0100, 16'h0040, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    send(16'h0100, 16'h0040, 1'b0, 1'b0);
    send(16'h0100, 16'h0040, 1'b0, 1'b1);
    drain();
    n_total++;
    if (q_r.size() !== 1) $display("FAIL acc_count got=%0d want=1", q_r.size()); else n_pass++;
    n_total++;
    if (q_r[0] !== 17'h00100) $display("FAIL acc_result got=%h want=00100", q_r[0]); else n_pass++;
    n_total++;
    if (q_t[0] !== 17'h00100) $display("FAIL acc_t_result got=%h want=00100", q_t[0]); else n_pass++;
  endtask

  task automatic test_saturation();
    q_r.delete(); q_t.delete();
    send(16'h7FFF, 16'h7FFF, 1'b1, 1'b1);
    send(16'h8000, 16'h7FFF, 1'b1, 1'b1);
    drain();
    n_total++;
    if (q_r.size() !== 2) $display("FAIL sat_count got=%0d want=2", q_r.size()); else n_pass++;
    n_total++;
    if (q_r[0] !== 17'h17FFF) $display("FAIL sat_pos got=%h want=17fff", q_r[0]); else n_pass++;
    n_total++;
    if (q_r[1] !== 17'h18000) $display("FAIL sat_neg got=%h want=18000", q_r[1]); else n_pass++;
    n_total++;
    if (q_t[0] !== 17'h1FF00) $display("FAIL wrap_pos got=%h want=1ff00", q_t[0]); else n_pass++;
    n_total++;
    if (q_t[1] !== 17'h10080) $display("FAIL wrap_neg got=%h want=10080", q_t[1]); else n_pass++;
  endtask

  task automatic test_rounding();
    q_r.delete(); q_t.delete();
    send(16'h0001, 16'h0080, 1'b1, 1'b1);
    send(16'hFFFF, 16'h0080, 1'b1, 1'b1);
    drain();
    n_total++;
    if (q_r[0] !== 17'h00001) $display("FAIL round_pos got=%h want=00001", q_r[0]); else n_pass++;
    n_total++;
    if (q_r[1] !== 17'h00000) $display("FAIL round_neg got=%h want=00000", q_r[1]); else n_pass++;
    n_total++;
    if (q_t[0] !== 17'h00000) $display("FAIL trunc_pos got=%h want=00000", q_t[0]); else n_pass++;
    n_total++;
    if (q_t[1] !== 17'h0FFFF) $display("FAIL trunc_neg got=%h want=0ffff", q_t[1]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int best;
    q_r.delete(); q_t.delete();
    best = 0;
    fork
      begin
        send(16'h0100, 16'h0100, 1'b1, 1'b1);
        send(16'h0200, 16'h0100, 1'b1, 1'b1);
        send(16'h0300, 16'h0100, 1'b1, 1'b1);
      end
      begin
        int run;
        run = 0;
        repeat (8) begin
          @(negedge clk);
          if (out_valid) run++; else run = 0;
          if (run > best) best = run;
        end
      end
    join
    drain();
    n_total++;
    if (best !== 3) $display("FAIL b2b_valid_run got=%0d want=3", best); else n_pass++;
    n_total++;
    if (q_r.size() !== 3) $display("FAIL b2b_count got=%0d want=3", q_r.size()); else n_pass++;
    n_total++;
    if (q_r[2] !== 17'h00300) $display("FAIL b2b_third got=%h want=00300", q_r[2]); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit held_ok;
    q_r.delete(); q_t.delete();
    out_ready = 1'b0;
    held_ok = 1;
    fork
      begin
        send(16'h0100, 16'h0100, 1'b1, 1'b1);
        send(16'h0100, 16'h0200, 1'b1, 1'b1);
        send(16'h0100, 16'h0300, 1'b1, 1'b1);
      end
      begin
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        if (!out_valid) held_ok = 0;
        repeat (5) begin
          @(negedge clk);
          if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'h0100) held_ok = 0;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    n_total++;
    if (held_ok !== 1'b1) $display("FAIL bp_hold got=%b want=1", held_ok); else n_pass++;
    n_total++;
    if (q_r.size() !== 3) $display("FAIL bp_count got=%0d want=3", q_r.size()); else n_pass++;
    n_total++;
    if (q_r[0] !== 17'h00100) $display("FAIL bp_first got=%h want=00100", q_r[0]); else n_pass++;
    n_total++;
    if (q_r[1] !== 17'h00200) $display("FAIL bp_second got=%h want=00200", q_r[1]); else n_pass++;
    n_total++;
    if (q_r[2] !== 17'h00300) $display("FAIL bp_third got=%h want=00300", q_r[2]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    // Reset while a result is held under backpressure.
    out_ready = 1'b0;
    send(16'h0100, 16'h0200, 1'b1, 1'b1);
    for (int i = 0; i < 5 && !out_valid; i++) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL rst_stall_valid got=%b want=0", out_valid); else n_pass++;
    n_total++;
    if (out_data !== 16'h0000) $display("FAIL rst_stall_data got=%h want=0000", out_data); else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL rst_stall_ready got=%b want=1", in_ready); else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    // Reset after two of four accumulation beats.
    send(16'h0100, 16'h0100, 1'b1, 1'b0);
    send(16'h0100, 16'h0100, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL rst_mid_valid got=%b want=0", out_valid); else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL rst_mid_ready got=%b want=1", in_ready); else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q_r.delete(); q_t.delete();
    send(16'h0100, 16'h0100, 1'b0, 1'b1);
    send(16'h0100, 16'h0100, 1'b1, 1'b1);
    drain();
    n_total++;
    if (q_r.size() !== 2) $display("FAIL rst_after_count got=%0d want=2", q_r.size()); else n_pass++;
    n_total++;
    if (q_r[0] !== 17'h00100) $display("FAIL rst_acc_cleared got=%h want=00100", q_r[0]); else n_pass++;
    n_total++;
    if (q_r[1] !== 17'h00100) $display("FAIL rst_fresh got=%h want=00100", q_r[1]); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_accumulate();
    test_saturation();
    test_rounding();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
